// File: rtl/cpu_thread_sched.sv
// Round-robin hardware-thread scheduler: tracks per-thread ready flags and saved IPs,
// and sequences invalidate/reload pulses to the pipeline when the running thread yields.
module cpu_thread_sched #(
    parameter int N_THREADS     = 4,
    parameter int N_THREADS_MSB = 1,
    parameter int IP_WIDTH      = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [N_THREADS-1:0]     ready_set,
    input  logic                     switch_req,
    input  logic                     switch_wait,
    input  logic [IP_WIDTH-1:0]      switch_ip,
    output logic                     invalidate,
    output logic                     reload,
    output logic [N_THREADS_MSB:0]   thread_num,
    output logic [IP_WIDTH-1:0]      ip_load,
    output logic                     idle,
    output logic [N_THREADS-1:0]     thread_ready
);

    typedef enum logic {PICK, RUN} state_t;

    state_t                 state;
    logic [N_THREADS-1:0]   ready;
    logic [IP_WIDTH-1:0]    ip_mem [N_THREADS];

    logic                   accept;
    logic [N_THREADS-1:0]   clr_mask;
    logic [N_THREADS-1:0]   cand;
    logic                   found;
    logic [N_THREADS_MSB:0] sel;

    // A yield in the reload cycle is dropped so the restarted thread gets at least one cycle.
    assign accept       = (state == RUN) && switch_req && !reload;
    assign cand         = ready | ready_set;
    assign thread_ready = ready;

    always_comb begin
        clr_mask = '0;
        if (accept && switch_wait)
            clr_mask[thread_num] = 1'b1;
    end

    // Search starts after the current thread and wraps; the current thread is tried last.
    always_comb begin
        found = 1'b0;
        sel   = thread_num;
        for (int k = 1; k <= N_THREADS; k++) begin
            if (!found && cand[thread_num + (N_THREADS_MSB+1)'(k)]) begin
                found = 1'b1;
                sel   = thread_num + (N_THREADS_MSB+1)'(k);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= PICK;
            ready      <= '0;
            invalidate <= 1'b0;
            reload     <= 1'b0;
            thread_num <= '0;
            ip_load    <= '0;
            idle       <= 1'b1;
            for (int i = 0; i < N_THREADS; i++)
                ip_mem[i] <= '0;
        end else begin
            // Set is applied after clear so a coincident wake-up is never lost.
            ready <= (ready & ~clr_mask) | ready_set;
            case (state)
                RUN: begin
                    reload     <= 1'b0;
                    invalidate <= accept;
                    if (accept) begin
                        ip_mem[thread_num] <= switch_ip;
                        state              <= PICK;
                    end
                end
                default: begin
                    invalidate <= 1'b0;
                    if (found) begin
                        thread_num <= sel;
                        ip_load    <= ip_mem[sel];
                        reload     <= 1'b1;
                        idle       <= 1'b0;
                        state      <= RUN;
                    end else begin
                        reload <= 1'b0;
                        idle   <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
